mem_access_unit: RTL
====================

# mem_access_unit

Sub-word load/store front end placed between the EX/MEM pipeline register and `DataMemory`. It turns pipeline memory requests (byte, halfword or word; signed or unsigned loads) into word-wide `DataMemory` accesses. Sub-word stores become a two-cycle read-modify-write with a pipeline stall. Load data is extracted, extended and registered for the MEM/WB stage, and misaligned accesses are suppressed and flagged.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width. Fixed at 32; other values are unsupported.
- `Clk` input 1: rising-edge clock.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Address` input 32: byte address from EX/MEM.
- `WriteData` input 32: store data, right-justified.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request.
- `Size` input 2: access size. 00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `Unsigned` input 1: zero-extend loads when 1, sign-extend when 0.
- `ErrClr` input 1: clears `AlignErr`.
- `Stall` output 1: holds the upstream pipeline.
- `LoadData` output 32: registered, extended load result.
- `LoadValid` output 1: `LoadData` was updated at the last edge.
- `AlignErr` output 1: sticky misalignment flag.
- `ErrAddr` output 32: address of the first misaligned access.
- `Mem_Address` output 32: word-aligned address to `DataMemory`.
- `Mem_WriteData` output 32: word written to `DataMemory`.
- `Mem_MemRead` output 1: read enable to `DataMemory`.
- `Mem_MemWrite` output 1: write enable to `DataMemory`.
- `Mem_ReadData` input 32: combinational read data from `DataMemory`.

## Operation
- Byte lanes are little-endian: lane k is bits [8k+7:8k], selected by `Address[1:0]`. `Mem_Address` = {`Address[31:2]`, 2'b00}, or the latched address during RMW_WRITE.
- Alignment rule: a half is misaligned when `Address[0]`=1; a word is misaligned when `Address[1:0]`≠0. A byte access is never misaligned.
- A misaligned request:
  - asserts no memory enable and no `Stall`;
  - sets `AlignErr` at the edge;
  - loads `ErrAddr` only if `AlignErr` was 0.
- `ErrClr` clears `AlignErr` at the edge. A simultaneous new error wins: the flag stays 1 and `ErrAddr` is reloaded.
- `MemWrite` has priority. If `MemRead` and `MemWrite` are both 1, the request is a store and `LoadValid`=0.
- FSM has two states, IDLE and RMW_WRITE.
- IDLE, aligned word store: `Mem_MemWrite`=1, `Mem_WriteData`=`WriteData`, `Stall`=0. Completes in one cycle.
- IDLE, aligned byte/half store:
  - `Mem_MemRead`=1, `Stall`=1 (combinational).
  - At the edge, latch the word address and the merged word: `Mem_ReadData` with the selected lane(s) replaced by `WriteData[7:0]` or `WriteData[15:0]`.
  - Go to RMW_WRITE.
- RMW_WRITE:
  - `Mem_MemWrite`=1, `Mem_WriteData`=merged word, `Mem_Address`=latched address, `Stall`=0.
  - Pipeline inputs are ignored; they still carry the held store.
  - Unconditionally return to IDLE.
- IDLE, aligned load: `Mem_MemRead`=1, `Stall`=0. At the edge:
  - `LoadData` ← selected byte/half/word, sign- or zero-extended per `Unsigned`;
  - `LoadValid` ← 1.
- In any cycle without an aligned load, `LoadValid` ← 0 and `LoadData` holds.
- Idle cycles (no request): all `Mem_*` enables are 0 and `Mem_WriteData` = `WriteData`.

## Timing
- Reset values: state=IDLE, `LoadData`=0, `LoadValid`=0, `AlignErr`=0, `ErrAddr`=0, merged word=0, latched address=0.
- Combinational outputs during reset: `Stall`=0 and all `Mem_*` enables are 0.
- Load latency: request in cycle N, `LoadData`/`LoadValid` valid after edge N.
- Word store: memory written at edge N.
- Sub-word store:
  - cycle N: read, `Stall`=1;
  - cycle N+1: write, `Stall`=0;
  - memory updated at edge N+1;
  - next request accepted in cycle N+2.
- Back-to-back sub-word stores to the same word must each read the updated word, which follows from the sequence above.
- Reset asserted in RMW_WRITE:
  - `Mem_MemWrite` drops immediately, because enables are gated by `Reset_n`;
  - no write is issued;
  - state returns to IDLE.
- `Stall` is never asserted in RMW_WRITE or for misaligned, load or word-store requests.

## Test plan
- Word store then load. Store 0x12345678 to 0x10, then signed word load from 0x10:
  - `Mem_MemWrite` asserted for 1 cycle;
  - next cycle `LoadData`=0x12345678, `LoadValid`=1.
- Byte RMW. Memory[0x10]=0x12345678; byte store of 0xAB to 0x11:
  - `Stall`=1 for exactly 1 cycle;
  - memory becomes 0x1234AB78;
  - unsigned byte load from 0x11 returns 0x000000AB;
  - signed byte load from 0x11 returns 0xFFFFFFAB.
- Half RMW. Half store of 0xBEEF to 0x12 on 0x1234AB78:
  - memory becomes 0xBEEFAB78;
  - signed half load from 0x12 returns 0xFFFFBEEF.
- Misaligned accesses:
  - word load from 0x13 gives no `Mem_*` enable, `AlignErr`=1, `ErrAddr`=0x13;
  - a later half store to 0x15 leaves `ErrAddr`=0x13;
  - `ErrClr` then returns `AlignErr` to 0.
- Priority. `MemRead`=`MemWrite`=1, word store of 0x2 to 0x4: memory[0x4]=0x2 and `LoadValid`=0.
- Reset mid-RMW. Byte store to 0x21, then drop `Reset_n` during RMW_WRITE:
  - memory is unchanged;
  - all outputs are at reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_access_unit                                               |
// | Brief    : Sub-word load/store front end between EX/MEM and DataMemory.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic              ErrClr,
    output logic              Stall,
    output logic [DATA_W-1:0] LoadData,
    output logic              LoadValid,
    output logic              AlignErr,
    output logic [ADDR_W-1:0] ErrAddr,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WriteData,
    output logic              Mem_MemRead,
    output logic              Mem_MemWrite,
    input  logic [DATA_W-1:0] Mem_ReadData
);

    localparam logic [0:0] c_IDLE      = 1'b0;
    localparam logic [0:0] c_RMW_WRITE = 1'b1;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_rmwAddr;
    logic [DATA_W-1:0] r_mergedWord;

    logic              w_isByte;
    logic              w_isHalf;
    logic              w_isWord;
    logic              w_misalign;
    logic              w_idle;
    logic              w_goodStore;
    logic              w_wordStore;
    logic              w_subStore;
    logic              w_goodLoad;
    logic              w_alignFault;
    logic [ADDR_W-1:0] w_wordAddr;
    logic [DATA_W-1:0] w_mergedWord;
    logic [7:0]        w_loadByte;
    logic [15:0]       w_loadHalf;
    logic [DATA_W-1:0] w_loadExt;

    // Reserved size code 11 falls through to word handling.
    assign w_isByte   = (Size == c_SIZE_BYTE);
    assign w_isHalf   = (Size == c_SIZE_HALF);
    assign w_isWord   = Size[1];
    assign w_misalign = (w_isHalf & Address[0]) | (w_isWord & (|Address[1:0]));

    assign w_idle       = (r_state == c_IDLE);
    assign w_goodStore  = w_idle & MemWrite & ~w_misalign;
    assign w_wordStore  = w_goodStore & w_isWord;
    assign w_subStore   = w_goodStore & ~w_isWord;
    assign w_goodLoad   = w_idle & MemRead & ~MemWrite & ~w_misalign;
    assign w_alignFault = w_idle & (MemRead | MemWrite) & w_misalign;
    assign w_wordAddr   = {Address[ADDR_W-1:2], 2'b00};

    // Enables are gated by reset so an in-flight RMW write is dropped at once.
    assign Stall         = Reset_n & w_subStore;
    assign Mem_MemRead   = Reset_n & (w_subStore | w_goodLoad);
    assign Mem_MemWrite  = Reset_n & (w_wordStore | ~w_idle);
    assign Mem_Address   = w_idle ? w_wordAddr : r_rmwAddr;
    assign Mem_WriteData = w_idle ? WriteData : r_mergedWord;

    always_comb begin
        w_mergedWord = Mem_ReadData;
        if (w_isByte) begin
            case (Address[1:0])
                2'd0:    w_mergedWord[7:0]   = WriteData[7:0];
                2'd1:    w_mergedWord[15:8]  = WriteData[7:0];
                2'd2:    w_mergedWord[23:16] = WriteData[7:0];
                default: w_mergedWord[31:24] = WriteData[7:0];
            endcase
        end else if (Address[1]) begin
            w_mergedWord[31:16] = WriteData[15:0];
        end else begin
            w_mergedWord[15:0] = WriteData[15:0];
        end
    end

    always_comb begin
        case (Address[1:0])
            2'd0:    w_loadByte = Mem_ReadData[7:0];
            2'd1:    w_loadByte = Mem_ReadData[15:8];
            2'd2:    w_loadByte = Mem_ReadData[23:16];
            default: w_loadByte = Mem_ReadData[31:24];
        endcase
        w_loadHalf = Address[1] ? Mem_ReadData[31:16] : Mem_ReadData[15:0];
        if (w_isByte) begin
            w_loadExt = {{24{~Unsigned & w_loadByte[7]}}, w_loadByte};
        end else if (w_isHalf) begin
            w_loadExt = {{16{~Unsigned & w_loadHalf[15]}}, w_loadHalf};
        end else begin
            w_loadExt = Mem_ReadData;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= c_IDLE;
            r_rmwAddr    <= '0;
            r_mergedWord <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_subStore) begin
                        r_state      <= c_RMW_WRITE;
                        r_rmwAddr    <= w_wordAddr;
                        r_mergedWord <= w_mergedWord;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            LoadData  <= '0;
            LoadValid <= 1'b0;
        end else begin
            LoadValid <= w_goodLoad;
            if (w_goodLoad) begin
                LoadData <= w_loadExt;
            end
        end
    end

    // A new fault in the same cycle as ErrClr re-captures its address.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            AlignErr <= 1'b0;
            ErrAddr  <= '0;
        end else if (w_alignFault) begin
            AlignErr <= 1'b1;
            if (!AlignErr || ErrClr) begin
                ErrAddr <= Address;
            end
        end else if (ErrClr) begin
            AlignErr <= 1'b0;
        end
    end

endmodule
`default_nettype wire
